// File: rtl/neopix_frame_sched_if.sv
// Bus between the SPI frame writer / WS2812 driver side and the frame scheduler.
// The slave modport is the scheduler's view; master is the surrounding logic.
interface neopix_frame_sched_if #(
  parameter int W = 4
);
  logic         frame_done_i;
  logic         frame_bank_i;
  logic [W-1:0] frame_count_i;
  logic         ws_busy_i;
  logic         clear_i;
  logic         ws_start_o;
  logic         ws_bank_o;
  logic [W-1:0] ws_count_o;
  logic         spi_bank_o;
  logic         overrun_o;
  logic [15:0]  frames_o;

  modport slave (
    input  frame_done_i, frame_bank_i, frame_count_i, ws_busy_i, clear_i,
    output ws_start_o, ws_bank_o, ws_count_o, spi_bank_o, overrun_o, frames_o
  );

  modport master (
    output frame_done_i, frame_bank_i, frame_count_i, ws_busy_i, clear_i,
    input  ws_start_o, ws_bank_o, ws_count_o, spi_bank_o, overrun_o, frames_o
  );
endinterface

// File: rtl/neopix_frame_sched.sv
// neopix_frame_sched: ping-pong bank scheduler between an SPI frame writer and
// a WS2812 driver. Holds one pending frame, enforces the latch gap between
// frames, auto-repeats the last frame at the refresh rate and counts starts.
module neopix_frame_sched #(
  parameter int NUM_LEDS     = 8,
  parameter int SYSTEM_CLOCK = 50000000,
  parameter int LATCH_US     = 300,
  parameter int REFRESH_HZ   = 60
) (
  input  logic                clk_i,
  input  logic                reset_i,
  neopix_frame_sched_if.slave bus
);
  localparam int W            = $clog2(NUM_LEDS) + 1;
  localparam int LATCH_CYC    = SYSTEM_CLOCK / 1000000 * LATCH_US;
  // A zero latch time still needs one LATCH cycle for the state machine to pass through.
  localparam int LATCH_N      = (LATCH_CYC < 1) ? 1 : LATCH_CYC;
  localparam bit REFRESH_EN   = (REFRESH_HZ != 0);
  localparam int REFRESH_CYC  = REFRESH_EN ? (SYSTEM_CLOCK / REFRESH_HZ) : 1;
  localparam int TW           = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  // Shared counter covers both the 4-cycle busy timeout and the latch gap.
  localparam int CW           = ($clog2(LATCH_N) > 2) ? $clog2(LATCH_N) : 2;
  localparam int BUSY_TIMEOUT = 4;

  localparam logic [TW-1:0] TIMER_MAX = TW'(REFRESH_CYC - 1);
  localparam logic [W-1:0]  MAX_COUNT = W'(NUM_LEDS);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, BUSY, LATCH} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          pending_q, pending_d;
  logic          slot_bank_q, slot_bank_d;
  logic [W-1:0]  slot_count_q, slot_count_d;
  logic          ws_start_q, ws_start_d;
  logic          ws_bank_q, ws_bank_d;
  logic [W-1:0]  ws_count_q, ws_count_d;
  logic          spi_bank_q, spi_bank_d;
  logic          overrun_q, overrun_d;
  logic [15:0]   frames_q, frames_d;

  logic          accept;
  logic          dispatch;
  logic          refresh_due;
  logic          overrun_event;
  logic [W-1:0]  count_clamped;

  // Next-state logic: slot capture, overrun flag, FSM and registered outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pending_d    = pending_q;
    slot_bank_d  = slot_bank_q;
    slot_count_d = slot_count_q;
    ws_start_d   = 1'b0;
    ws_bank_d    = ws_bank_q;
    ws_count_d   = ws_count_q;
    spi_bank_d   = spi_bank_q;
    frames_d     = frames_q;
    // Timer reads 0 during the START cycle and counts every cycle after it.
    timer_d      = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);

    count_clamped = (bus.frame_count_i > MAX_COUNT) ? MAX_COUNT : bus.frame_count_i;
    accept        = bus.frame_done_i && (bus.frame_count_i != '0);
    dispatch      = (state_q == IDLE) && pending_q;
    refresh_due   = REFRESH_EN && (state_q == IDLE) && !pending_q &&
                    (timer_q >= TIMER_MAX) && (ws_count_q != '0);
    // A dispatch empties the slot this cycle, so a same-cycle frame is not an overrun.
    overrun_event = accept && pending_q && !dispatch;

    if (accept) begin
      pending_d    = 1'b1;
      slot_bank_d  = bus.frame_bank_i;
      slot_count_d = count_clamped;
    end else if (dispatch) begin
      pending_d = 1'b0;
    end

    overrun_d = overrun_q;
    if (bus.clear_i) overrun_d = 1'b0;
    if (overrun_event) overrun_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (dispatch || refresh_due) begin
          if (dispatch) begin
            ws_bank_d  = slot_bank_q;
            ws_count_d = slot_count_q;
            spi_bank_d = ~slot_bank_q;
          end
          state_d    = START;
          ws_start_d = 1'b1;
          frames_d   = frames_q + 16'd1;
          timer_d    = '0;
        end
      end
      START: begin
        state_d = WAIT_BUSY;
        cnt_d   = '0;
      end
      WAIT_BUSY: begin
        if (bus.ws_busy_i) begin
          state_d = BUSY;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          state_d = LATCH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BUSY: begin
        if (!bus.ws_busy_i) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == CW'(LATCH_N - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      slot_bank_q  <= 1'b0;
      slot_count_q <= '0;
      ws_start_q   <= 1'b0;
      ws_bank_q    <= 1'b0;
      ws_count_q   <= '0;
      spi_bank_q   <= 1'b1;
      overrun_q    <= 1'b0;
      frames_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      slot_bank_q  <= slot_bank_d;
      slot_count_q <= slot_count_d;
      ws_start_q   <= ws_start_d;
      ws_bank_q    <= ws_bank_d;
      ws_count_q   <= ws_count_d;
      spi_bank_q   <= spi_bank_d;
      overrun_q    <= overrun_d;
      frames_q     <= frames_d;
    end
  end

  assign bus.ws_start_o = ws_start_q;
  assign bus.ws_bank_o  = ws_bank_q;
  assign bus.ws_count_o = ws_count_q;
  assign bus.spi_bank_o = spi_bank_q;
  assign bus.overrun_o  = overrun_q;
  assign bus.frames_o   = frames_q;
endmodule

// File: doc/neopix_frame_sched.md
NEOPIX_FRAME_SCHED -- requirements
Module: neopix_frame_sched

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, max LEDs per frame; W = $clog2(NUM_LEDS)+1.
REQ-002 SHALL have parameter SYSTEM_CLOCK, default 50000000, clk_i frequency in Hz.
REQ-003 SHALL have parameter LATCH_US, default 300, minimum idle-low gap between WS2812 frames in us; LATCH_CYC = SYSTEM_CLOCK/1000000*LATCH_US.
REQ-004 SHALL have parameter REFRESH_HZ, default 60, auto-repeat rate; 0 disables; REFRESH_CYC = SYSTEM_CLOCK/REFRESH_HZ.
REQ-005 SHALL have ports:
- clk_i  in  1  single clock; all logic on rising edge
- reset_i  in  1  synchronous, active-low reset
- frame_done_i  in  1  one-cycle pulse: SPI writer finished a bank
- frame_bank_i  in  1  bank just written, valid with frame_done_i
- frame_count_i  in  W  LEDs written, valid with frame_done_i
- ws_busy_i  in  1  WS2812 driver busy
- clear_i  in  1  clears overrun_o
- ws_start_o  out  1  one-cycle start pulse to driver
- ws_bank_o  out  1  bank driver reads
- ws_count_o  out  W  LED count for driver
- spi_bank_o  out  1  bank SPI writer fills next
- overrun_o  out  1  sticky: pending frame overwritten
- frames_o  out  16  count of issued starts

Function
REQ-006 SHALL implement FSM states IDLE, START, WAIT_BUSY, BUSY, LATCH.
REQ-007 On frame_done_i with 1 <= frame_count_i <= NUM_LEDS, SHALL store {frame_bank_i, frame_count_i} in a one-deep pending slot and set pending.
REQ-008 frame_count_i > NUM_LEDS SHALL be clamped to NUM_LEDS; frame_count_i = 0 SHALL be ignored (no pending, no overrun).
REQ-009 frame_done_i while pending already set and not dispatched that cycle SHALL overwrite the slot and set overrun_o.
REQ-010 IDLE with pending SHALL load ws_bank_o/ws_count_o from the slot, set spi_bank_o = ~slot bank, clear pending, go START.
REQ-011 frame_done_i in the same cycle as a dispatch SHALL be captured into the emptied slot, no overrun.
REQ-012 IDLE without pending, REFRESH_HZ != 0, refresh timer >= REFRESH_CYC-1 and ws_count_o != 0 SHALL go START with bank/count unchanged.
REQ-013 START SHALL assert ws_start_o exactly one cycle, increment frames_o (wraps 16'hFFFF -> 0), clear refresh timer, go WAIT_BUSY.
REQ-014 WAIT_BUSY SHALL go BUSY on ws_busy_i=1; if ws_busy_i stays 0 for 4 cycles SHALL go LATCH (no hang).
REQ-015 BUSY SHALL go LATCH on first cycle ws_busy_i=0.
REQ-016 LATCH SHALL count LATCH_CYC cycles, then go IDLE; no start issued before the count completes.
REQ-017 ws_bank_o, ws_count_o, spi_bank_o SHALL change only on an IDLE dispatch, never while in START/WAIT_BUSY/BUSY/LATCH.
REQ-018 Refresh timer SHALL increment every cycle outside START, saturate at REFRESH_CYC-1.
REQ-019 clear_i SHALL clear overrun_o next cycle; simultaneous overrun event SHALL win (overrun_o stays 1).
REQ-020 Latency frame_done_i (FSM IDLE, no pending) to ws_start_o SHALL be exactly 2 cycles.

Reset
REQ-021 reset_i=0 at a clock edge SHALL force: state IDLE, pending 0, ws_start_o 0, ws_bank_o 0, ws_count_o 0, spi_bank_o 1, overrun_o 0, frames_o 0, timers 0.
REQ-022 Reset mid-frame (any state) SHALL apply REQ-021 next edge; pending frame discarded, no start pulse.

Verification (NUM_LEDS=8, SYSTEM_CLOCK=1000000, LATCH_US=10 -> LATCH_CYC=10, REFRESH_HZ=10000 -> REFRESH_CYC=100)
REQ-023 Basic: frame_done_i bank 1 count 8 at cycle t -> ws_start_o at t+2, ws_bank_o=1, ws_count_o=8, spi_bank_o=0, frames_o=1.
REQ-024 Latch gap: driver busy 50 cycles, second frame_done_i during busy -> second start no earlier than 10 cycles after busy falls; overrun_o=0.
REQ-025 Overrun: two frame_done_i (counts 3 then 5) during one busy -> overrun_o=1, next dispatch ws_count_o=5; clear_i -> overrun_o=0.
REQ-026 Clamp/ignore: count 12 -> ws_count_o=8; count 0 -> no start, no overrun.
REQ-027 Refresh and timeout: no new frames, ws_busy_i held 0 -> repeat starts every 100 cycles (WAIT_BUSY timeout + LATCH included), same bank/count; REFRESH_HZ=0 -> none.
REQ-028 Reset in BUSY with pending set -> outputs per REQ-021, no ws_start_o after reset release until new frame_done_i.
